pipe_sched: RTL and testbench
=============================

# pipe_sched

Request scheduler for the shared 3-stage arithmetic pipeline (F = ((A+B)+(C−D))·D, N-bit, latency 3 clocks). Up to NREQ requesters submit operand sets over valid/ready; the block grants one per cycle, drives the pipeline operand inputs, tracks each in-flight operation with a tag shift register, and routes the result back to the issuing requester. It also provides a drain/halt control so the pipeline can be quiesced.

## Interface
- N, default 10: operand/result width; must match the pipeline.
- NREQ, default 4: number of requesters, 2..8.
- clk  in  1  rising-edge clock shared with the pipeline.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant/accept, at most one bit high.
- req_a, req_b, req_c, req_d  in  NREQ·N each  packed operands; requester i occupies bits [i·N +: N].
- pipe_a, pipe_b, pipe_c, pipe_d  out  N  operands to pipeline stage 1.
- pipe_f  in  N  pipeline result.
- rsp_valid  out  NREQ  one-hot result strobe, one cycle per result.
- rsp_data  out  N  result data, valid when any rsp_valid bit is high.
- drain_req  in  1  request to stop issuing and empty the pipeline.
- halted  out  1  high when drained and idle.

## Operation
- State machine with states RUN, DRAIN and HALTED; reset state is RUN.
  - RUN → DRAIN when drain_req=1.
  - DRAIN → HALTED when the tag pipe is empty.
  - HALTED → RUN when drain_req=0.
  - DRAIN → RUN if drain_req drops before the pipe is empty.
- In RUN, the arbiter picks one of the req_valid bits. req_ready[g]=1 is combinational from req_valid and the arbiter state. req_valid must not depend on req_ready.
- In DRAIN and HALTED, req_ready=0.
- Grant g drives pipe_a..d with requester g's operands in the same cycle. With no grant, pipe_a..d=0.
- A transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge. The pipeline captures the operands at that same edge.
- Tag pipe:
  - 3 entries of {valid, tag[$clog2(NREQ)-1:0]}, shifted every clock.
  - Entry 0 loads {transfer, g}.
  - rsp_valid = onehot(entry2.tag) & entry2.valid; rsp_data = pipe_f (combinational).
- Responses have no back-pressure: requesters must accept rsp_valid unconditionally. The pipeline never stalls.
- Results are the pipeline's N-bit truncation (mod 2^N). The block performs no arithmetic on data.
- Reset values: all tag-pipe valids=0, state=RUN, arbiter pointer=NREQ−1 (so requester 0 wins first). Outputs: rsp_valid=0, req_ready=0 while reset asserted, halted=0.
- Reset asserted mid-operation discards all in-flight results. The pipeline registers are not reset; their contents are ignored because the tag valids are cleared.
- halted=1 exactly when state=HALTED.

## Timing
- Issue throughput: 1 operation/cycle.
- Latency: a transfer at edge k gives rsp_valid high in the cycle after edge k+2, so it is sampled at edge k+3.
- Back-to-back issues produce back-to-back responses in issue order.
- drain_req seen at edge k: transfers are blocked from the following cycle onward. A transfer at edge k itself still completes. halted rises after the last response leaves the tag pipe.
- Simultaneous drain_req and req_valid in RUN: the grant for that cycle proceeds, because state changes only at the edge.

## Configuration
- PIPE_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest-index valid requester always wins and the arbiter pointer is unused.
  - Undefined (default): round-robin; the search starts at pointer+1 and wraps at NREQ. The pointer updates to g only on a transfer.

## Structure
- Package pipe_sched_pkg:
  - PIPE_LAT=3.
  - State enum sched_state_t {RUN, DRAIN, HALTED}.
  - Tag-entry struct typedef.
  - Default N.
- Sub-module rr_arbiter (req[NREQ], en, ptr update on accept, grant one-hot) holds the round-robin/fixed-priority logic under the macro. pipe_sched instantiates it once.

## Test plan
- Single op: requester 0 sends A=3, B=4, C=10, D=2 at edge k → rsp_valid[0] sampled at edge k+3 with rsp_data=30; no other rsp_valid bits.
- Round-robin: all 4 requesters hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; responses carry matching one-hot tags 3 cycles later. With PIPE_SCHED_FIXED_PRIO_EN, requester 0 is granted in all 8 cycles.
- Wrap-around: requester 1 sends A=1023, B=1, C=0, D=0 → rsp_data=0.
- Overflow: requester 1 sends A=500, B=0, C=12, D=3 → (500+9)·3 mod 1024 = 503.
- Drain: issue 3 back-to-back ops, assert drain_req on the third issue edge → all 3 responses arrive; halted=1 the cycle after the last response; req_ready stays 0 while halted; deasserting drain_req restores grants next cycle.
- Reset mid-flight: assert rst_n=0 one cycle after 2 issues → rsp_valid=0 immediately and stays 0 after release; a new op after release returns its correct result with latency 3.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared types and constants for the pipeline request scheduler
package pipe_sched_pkg;

  localparam int PIPE_LAT  = 3;
  localparam int N_DEFAULT = 10;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_W     = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot requester arbiter; round-robin by default,
// fixed lowest-index priority when PIPE_SCHED_FIXED_PRIO_EN is defined
module rr_arbiter
  import pipe_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  input  logic                    accept,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic found;

`ifdef PIPE_SCHED_FIXED_PRIO_EN
  logic unused_inputs;
  assign unused_inputs = clk ^ rst_n ^ accept;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDX_W'(i) > ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    found     = hi_found | lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    ptr_d = accept ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign grant = (en && found) ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - request scheduler for the shared 3-stage arithmetic pipeline
// PIPE_SCHED_FIXED_PRIO_EN selects fixed-priority instead of round-robin arbitration
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  input  logic [NREQ*N-1:0] req_d,
  output logic [N-1:0]      pipe_a,
  output logic [N-1:0]      pipe_b,
  output logic [N-1:0]      pipe_c,
  output logic [N-1:0]      pipe_d,
  input  logic [N-1:0]      pipe_f,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  input  logic              drain_req,
  output logic              halted
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_t     state_q, state_d;
  tag_entry_t       tag_q [PIPE_LAT];
  tag_entry_t       tag_d [PIPE_LAT];
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             arb_en;
  logic             transfer;
  logic             pipe_empty_next;

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign arb_en = rst_n && (state_q == RUN);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .en       (arb_en),
    .accept   (transfer),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign transfer  = |grant;
  assign req_ready = grant;

  always_comb begin
    pipe_a = '0;
    pipe_b = '0;
    pipe_c = '0;
    pipe_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        pipe_a = req_a[i*N +: N];
        pipe_b = req_b[i*N +: N];
        pipe_c = req_c[i*N +: N];
        pipe_d = req_d[i*N +: N];
      end
    end
  end

  always_comb begin
    tag_d[0] = '{valid: transfer, tag: TAG_W'(grant_idx)};
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Looking at the next tag state lets halted rise right after the last response.
  always_comb begin
    pipe_empty_next = 1'b1;
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (tag_d[i].valid) begin
        pipe_empty_next = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drain_req)           state_d = RUN;
        else if (pipe_empty_next) state_d = HALTED;
      end
      HALTED: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rsp_valid = tag_q[PIPE_LAT-1].valid ? (NREQ'(1) << tag_q[PIPE_LAT-1].tag) : '0;
  assign rsp_data  = pipe_f;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - self-checking bench for pipe_sched with a behavioural scheduler and pipeline model
module tb_pipe_sched;

  localparam int N    = 10;
  localparam int NREQ = 4;
`ifdef PIPE_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b, req_c, req_d;
  logic [N-1:0]      pipe_a, pipe_b, pipe_c, pipe_d;
  logic [N-1:0]      pipe_f;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic              drain_req;
  logic              halted;

  pipe_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_c    (req_c),
    .req_d    (req_d),
    .pipe_a   (pipe_a),
    .pipe_b   (pipe_b),
    .pipe_c   (pipe_c),
    .pipe_d   (pipe_d),
    .pipe_f   (pipe_f),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .drain_req(drain_req),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int f_model(input int a, input int b, input int c, input int d);
    int r;
    r = ((a + b) + (c - d)) * d;
    return r & ((1 << N) - 1);
  endfunction

  // Environment: the arithmetic pipeline itself (not reset, latency 3).
  logic [N-1:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= N'(f_model(int'(pipe_a), int'(pipe_b), int'(pipe_c), int'(pipe_d)));
    s2 <= s1;
    s3 <= s2;
  end
  assign pipe_f = s3;

  // Scheduler model: mode 0=RUN 1=DRAIN 2=HALTED; pending responses by due cycle.
  typedef struct { int due; int tag; int data; } pend_t;
  typedef struct { int cyc; int idx; int data; } obs_t;
  pend_t pend[$];
  obs_t  rsp_log[$];
  int    gnt_log[$];
  int    cyc = 0;
  int    m_mode = 0;
  int    m_last = NREQ - 1;
  int    m_last_rsp = -100;

  function automatic int opv(input logic [NREQ*N-1:0] v, input int i);
    return int'(v[i*N +: N]);
  endfunction

  function automatic int model_winner();
    if (!rst_n || m_mode != 0) return -1;
    if (FIXED) begin
      for (int i = 0; i < NREQ; i++) if (req_valid[i]) return i;
    end else begin
      for (int k = 1; k <= NREQ; k++) if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int w;
    forever begin
      @(posedge clk);
      w = model_winner();
      cyc++;
      if (!rst_n) begin
        m_mode     = 0;
        m_last     = NREQ - 1;
        m_last_rsp = -100;
        pend.delete();
      end else begin
        if (w >= 0) begin
          pend.push_back('{cyc + 2, w, f_model(opv(req_a, w), opv(req_b, w), opv(req_c, w), opv(req_d, w))});
          m_last     = w;
          m_last_rsp = cyc + 2;
        end
        case (m_mode)
          0: if (drain_req) m_mode = 1;
          1: if (!drain_req) m_mode = 0; else if (m_last_rsp < cyc) m_mode = 2;
          default: if (!drain_req) m_mode = 0;
        endcase
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    int w, exp_rv, exp_rd, have;
    forever begin
      @(negedge clk);
      w = model_winner();
      chk("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
      chk("pipe_a", pipe_a, (w >= 0) ? opv(req_a, w) : 0);
      chk("pipe_b", pipe_b, (w >= 0) ? opv(req_b, w) : 0);
      chk("pipe_c", pipe_c, (w >= 0) ? opv(req_c, w) : 0);
      chk("pipe_d", pipe_d, (w >= 0) ? opv(req_d, w) : 0);
      chk("halted", halted, (rst_n && m_mode == 2) ? 1 : 0);
      exp_rv = 0;
      exp_rd = 0;
      have   = 0;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (rst_n) begin
          exp_rv = 1 << pend[0].tag;
          exp_rd = pend[0].data;
          have   = 1;
        end
        void'(pend.pop_front());
      end
      chk("rsp_valid", rsp_valid, exp_rv);
      if (have != 0) chk("rsp_data", rsp_data, exp_rd);
      if (|rsp_valid) rsp_log.push_back('{cyc, onehot_idx(rsp_valid), int'(rsp_data)});
      if (|req_ready) gnt_log.push_back(onehot_idx(req_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input int a, input int b, input int c, input int d);
    req_a[r*N +: N] = N'(a);
    req_b[r*N +: N] = N'(b);
    req_c[r*N +: N] = N'(c);
    req_d[r*N +: N] = N'(d);
  endtask

  task automatic one_op(input string nm, input int r, input int a, input int b, input int c,
                        input int d, input int exp);
    int k;
    rsp_log.delete();
    set_ops(r, a, b, c, d);
    req_valid = NREQ'(1) << r;
    tick();
    k = cyc;
    req_valid = '0;
    repeat (4) tick();
    chk({nm, "_count"}, rsp_log.size(), 1);
    if (rsp_log.size() >= 1) begin
      chk({nm, "_latency"}, rsp_log[0].cyc, k + 2);
      chk({nm, "_tag"}, rsp_log[0].idx, r);
      chk({nm, "_data"}, rsp_log[0].data, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k3;
    rst_n     = 1'b0;
    drain_req = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 10 * i + 1, i + 2, 3 * i, i + 1);
    req_valid = '1;
    tick();
    tick();
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_halted", halted, 0);

    // Round-robin: all requesters valid for 8 cycles.
    gnt_log.delete();
    rsp_log.delete();
    rst_n = 1'b1;
    repeat (8) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("rr_grant_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("rr_grant", gnt_log[i], FIXED ? 0 : i % 4);
    chk("rr_rsp_count", rsp_log.size(), 8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++) chk("rr_rsp_tag", rsp_log[i].idx, FIXED ? 0 : i % 4);

    one_op("single", 0, 3, 4, 10, 2, 30);
    one_op("wrap", 1, 1023, 1, 0, 0, 0);

    // Drain: three back-to-back issues, drain_req on the third issue edge.
    rsp_log.delete();
    set_ops(2, 7, 8, 9, 3);
    req_valid = 4'b0100;
    tick();
    tick();
    drain_req = 1'b1;
    tick();
    k3 = cyc;
    tick();
    tick();
    chk("drain_halted_early", halted, 0);
    tick();
    chk("drain_halted", halted, 1);
    chk("drain_ready_blocked", req_ready, 0);
    tick();
    tick();
    chk("halted_hold", halted, 1);
    chk("halted_ready", req_ready, 0);
    chk("drain_rsp_count", rsp_log.size(), 3);
    for (int i = 0; i < rsp_log.size(); i++) chk("drain_rsp_data", rsp_log[i].data, 63);
    if (rsp_log.size() == 3) chk("drain_last_rsp", rsp_log[2].cyc, k3 + 2);
    drain_req = 1'b0;
    tick();
    chk("resume_ready", req_ready, 4'b0100);
    chk("resume_halted", halted, 0);
    req_valid = '0;
    repeat (4) tick();

    // Reset mid-flight: two issues, reset one cycle later.
    set_ops(3, 100, 20, 30, 5);
    req_valid = 4'b1000;
    tick();
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    rsp_log.delete();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_no_rsp", rsp_log.size(), 0);
    one_op("overflow", 1, 500, 0, 12, 3, 503);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
